// File: rtl/final_project_soc_pkg.sv
// Shared constants for the RSA-result-to-software path: PIO width, status bit map
// and the word sequencer's state encoding.
package final_project_soc_pkg;

  localparam int DATA_W     = 32;

  localparam int ST_REQ     = 0;
  localparam int ST_LAST    = 1;
  localparam int ST_IDX_LSB = 8;
  localparam int ST_IDX_W   = 8;
  localparam int ST_BUSY    = 31;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PRESENT = 2'd1,
    S_RELEASE = 2'd2,
    S_DONE    = 2'd3
  } seq_state_e;

  // Word index width; a single-word result still carries a 1-bit index.
  function automatic int idx_width(input int num_words);
    return (num_words > 1) ? $clog2(num_words) : 1;
  endfunction

endpackage

// File: rtl/final_project_soc_to_sw_sequencer.sv
// Hands a captured multi-word RSA result to software one 32-bit word at a time
// over PIOs, using a four-phase req/ack handshake with a level-sensitive abort.
module final_project_soc_to_sw_sequencer
  import final_project_soc_pkg::*;
#(
  parameter int NUM_WORDS = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          result_valid,
  input  logic [NUM_WORDS*DATA_W-1:0]   result_data,
  output logic                          result_ready,
  input  logic                          sw_ack,
  input  logic                          sw_abort,
  output logic [DATA_W-1:0]             to_sw_data,
  output logic [31:0]                   to_sw_status,
  output logic                          xfer_done
);

  localparam int                IDX_W    = idx_width(NUM_WORDS);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_WORDS - 1);

  seq_state_e          state_q, state_d;
  logic [DATA_W-1:0]   buf_q [NUM_WORDS];
  logic [DATA_W-1:0]   buf_d [NUM_WORDS];
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [IDX_W-1:0]    idx_inc;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                req_q, req_d;
  logic                last_q, last_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                ready_q, ready_d;

  assign idx_inc = idx_q + IDX_W'(1);

  // NOTE: every _d gets a default before the case so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    idx_d   = idx_q;
    data_d  = data_q;
    req_d   = req_q;
    last_d  = last_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    ready_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        // An asserted abort parks the block in IDLE with capture blocked.
        ready_d = !sw_abort;
        if (result_valid && ready_q && !sw_abort) begin
          for (int i = 0; i < NUM_WORDS; i++) begin
            buf_d[i] = result_data[i*DATA_W +: DATA_W];
          end
          idx_d   = '0;
          data_d  = result_data[DATA_W-1:0];
          req_d   = 1'b1;
          busy_d  = 1'b1;
          last_d  = (NUM_WORDS == 1);
          ready_d = 1'b0;
          state_d = S_PRESENT;
        end
      end

      S_PRESENT: begin
        // A level ack counts even if it was already high on entry.
        if (sw_ack) begin
          req_d   = 1'b0;
          state_d = S_RELEASE;
        end
      end

      S_RELEASE: begin
        if (!sw_ack) begin
          if (last_q) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            last_d  = 1'b0;
            idx_d   = '0;
            data_d  = '0;
            state_d = S_DONE;
          end else begin
            idx_d   = idx_inc;
            data_d  = buf_q[idx_inc];
            req_d   = 1'b1;
            last_d  = (idx_inc == LAST_IDX);
            state_d = S_PRESENT;
          end
        end
      end

      S_DONE: begin
        ready_d = !sw_abort;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    // Abort overrides everything outside IDLE, including a coincident ack.
    if (sw_abort && (state_q != S_IDLE)) begin
      for (int i = 0; i < NUM_WORDS; i++) begin
        buf_d[i] = '0;
      end
      idx_d   = '0;
      data_d  = '0;
      req_d   = 1'b0;
      last_d  = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      ready_d = 1'b0;
      state_d = S_IDLE;
    end
  end

  // NOTE: the word buffer is reset too, so a discarded result never lingers in flops.
  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      buf_q   <= '{default: '0};
      idx_q   <= '0;
      data_q  <= '0;
      req_q   <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      req_q   <= req_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ready_q <= ready_d;
    end
  end

  always_comb begin
    to_sw_status                            = '0;
    to_sw_status[ST_REQ]                    = req_q;
    to_sw_status[ST_LAST]                   = last_q;
    to_sw_status[ST_IDX_LSB +: ST_IDX_W]    = ST_IDX_W'(idx_q);
    to_sw_status[ST_BUSY]                   = busy_q;
  end

  assign to_sw_data   = data_q;
  assign xfer_done    = done_q;
  assign result_ready = ready_q;

endmodule

// File: tb/tb_final_project_soc_to_sw_sequencer.sv
// Randomized bench: a software-side reference walks each transfer word by word and
// checks data, status, ready and the done pulse against values derived from the result.
module tb_final_project_soc_to_sw_sequencer;

  localparam int NW = 4;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  always #5 clk = ~clk;

  logic            valid = 1'b0;
  logic [NW*32-1:0] rdata = '0;
  logic            ready;
  logic            ack = 1'b0;
  logic            abort_s = 1'b0;
  logic [31:0]     data;
  logic [31:0]     status;
  logic            done;

  logic            valid1 = 1'b0;
  logic [31:0]     rdata1 = '0;
  logic            ready1;
  logic            ack1 = 1'b0;
  logic            abort1 = 1'b0;
  logic [31:0]     data1;
  logic [31:0]     status1;
  logic            done1;

  final_project_soc_to_sw_sequencer #(.NUM_WORDS(NW)) u_dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .result_valid (valid),
    .result_data  (rdata),
    .result_ready (ready),
    .sw_ack       (ack),
    .sw_abort     (abort_s),
    .to_sw_data   (data),
    .to_sw_status (status),
    .xfer_done    (done)
  );

  final_project_soc_to_sw_sequencer #(.NUM_WORDS(1)) u_dut1 (
    .clk          (clk),
    .reset_n      (reset_n),
    .result_valid (valid1),
    .result_data  (rdata1),
    .result_ready (ready1),
    .sw_ack       (ack1),
    .sw_abort     (abort1),
    .to_sw_data   (data1),
    .to_sw_status (status1),
    .xfer_done    (done1)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int done_cnt = 0;

  always @(posedge clk) if (done) done_cnt++;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
  endtask

  function automatic logic [31:0] exp_status(input bit req, input bit last, input int idx, input bit busy);
    logic [31:0] s;
    s = (32'(idx) & 32'hff) << 8;
    if (req)  s = s | 32'h1;
    if (last) s = s | 32'h2;
    if (busy) s = s | 32'h8000_0000;
    return s;
  endfunction

  function automatic logic [NW*32-1:0] rand_result();
    logic [NW*32-1:0] r;
    for (int k = 0; k < NW; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic wait_ready(input string tag);
    int guard;
    guard = 0;
    while (ready !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check(tag, ready, 1);
  endtask

  // One full transfer on the 4-word instance, called at a negedge with the DUT idle.
  task automatic run_xfer(input logic [NW*32-1:0] res, input int first_hold, input int abort_at,
                          input bit hold_next, input logic [NW*32-1:0] next_res);
    logic [31:0] w [NW];
    int base;
    int hold;
    int rel_hold;
    for (int k = 0; k < NW; k++) w[k] = res[k*32 +: 32];
    base  = done_cnt;
    valid = 1'b1;
    rdata = res;
    wait_ready("ready_before_capture");
    @(negedge clk);
    if (hold_next) rdata = next_res;
    else valid = 1'b0;
    for (int k = 0; k < NW; k++) begin
      hold = (k == 0 && first_hold >= 0) ? first_hold : int'($urandom_range(0, 3));
      for (int c = 0; c <= hold; c++) begin
        check("present_status", status, exp_status(1, k == NW-1, k, 1));
        check("present_data", data, w[k]);
        check("ready_busy", ready, 0);
        if (c < hold) @(negedge clk);
      end
      ack = 1'b1;
      @(negedge clk);
      rel_hold = $urandom_range(0, 2);
      for (int c = 0; c <= rel_hold; c++) begin
        check("release_status", status, exp_status(0, k == NW-1, k, 1));
        check("release_data", data, w[k]);
        if (c < rel_hold) @(negedge clk);
      end
      if (k == abort_at) begin
        abort_s = 1'b1;
        @(negedge clk);
        check("abort_status", status, 0);
        check("abort_data", data, 0);
        check("abort_ready_low", ready, 0);
        check("abort_no_done", done, 0);
        abort_s = 1'b0;
        ack     = 1'b0;
        @(negedge clk);
        check("abort_ready_back", ready, 1);
        check("abort_idle_status", status, 0);
        check("abort_done_cnt", done_cnt, base);
        return;
      end
      ack = 1'b0;
      @(negedge clk);
    end
    check("done_pulse", done, 1);
    check("done_status", status, 0);
    check("done_data", data, 0);
    @(negedge clk);
    check("done_one_cycle", done, 0);
    check("idle_ready", ready, 1);
    check("done_cnt", done_cnt, base + 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [NW*32-1:0] r1;
    logic [NW*32-1:0] r2;

    repeat (2) @(negedge clk);
    check("rst_ready", ready, 1);
    check("rst_status", status, 0);
    check("rst_data", data, 0);
    check("rst_done", done, 0);
    check("rst_ready1", ready1, 1);
    reset_n = 1'b1;
    @(negedge clk);
    check("post_rst_status", status, 0);

    // Fixed pattern with immediate acks.
    r1 = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
    run_xfer(r1, 0, -1, 0, '0);

    // Software stalls 50 cycles on word 0.
    run_xfer(rand_result(), 50, -1, 0, '0);

    // Abort (with ack still high) in the idx=2 release phase.
    run_xfer(rand_result(), -1, 2, 0, '0);

    // New result held on the port during a transfer, then sent intact.
    r1 = rand_result();
    r2 = rand_result();
    run_xfer(r1, -1, -1, 1, r2);
    run_xfer(r2, -1, -1, 0, '0);

    // Abort held in IDLE blocks capture.
    abort_s = 1'b1;
    @(negedge clk);
    check("idle_abort_ready", ready, 0);
    valid = 1'b1;
    rdata = rand_result();
    repeat (2) @(negedge clk);
    check("idle_abort_no_capture", status, 0);
    valid   = 1'b0;
    abort_s = 1'b0;
    @(negedge clk);
    check("idle_abort_release", ready, 1);

    for (int t = 0; t < 5; t++) run_xfer(rand_result(), -1, -1, 0, '0);

    // Asynchronous reset mid-PRESENT.
    valid = 1'b1;
    rdata = rand_result();
    wait_ready("rst_mid_ready");
    @(negedge clk);
    valid = 1'b0;
    check("rst_mid_req", status, exp_status(1, 0, 0, 1));
    #2 reset_n = 1'b0;
    #1;
    check("rst_mid_status", status, 0);
    check("rst_mid_data", data, 0);
    check("rst_mid_ready_hi", ready, 1);
    check("rst_mid_done", done, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    run_xfer(rand_result(), -1, -1, 0, '0);

    // Single-word instance.
    for (int t = 0; t < 3; t++) begin
      int guard;
      logic [31:0] w;
      w      = $urandom;
      valid1 = 1'b1;
      rdata1 = w;
      guard  = 0;
      while (ready1 !== 1'b1 && guard < 20) begin
        @(negedge clk);
        guard++;
      end
      check("n1_ready", ready1, 1);
      @(negedge clk);
      valid1 = 1'b0;
      check("n1_present_status", status1, exp_status(1, 1, 0, 1));
      check("n1_present_data", data1, w);
      ack1 = 1'b1;
      @(negedge clk);
      check("n1_release_status", status1, exp_status(0, 1, 0, 1));
      check("n1_no_early_done", done1, 0);
      ack1 = 1'b0;
      @(negedge clk);
      check("n1_done", done1, 1);
      check("n1_done_status", status1, 0);
      check("n1_done_data", data1, 0);
      @(negedge clk);
      check("n1_done_clear", done1, 0);
      check("n1_idle_ready", ready1, 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
